// File: rtl/scan_cfg_loader.sv
// scan_cfg_loader: streams config bytes into a scan chain and returns the displaced bits as bytes.
module scan_cfg_loader #(
  parameter int CHAIN_LEN = 512,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       sc_en,
  output logic       sc_in,
  input  logic       sc_out,
  output logic       busy,
  output logic       done,
  output logic       aborted
);
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, EMIT, FIN} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN);
  state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0] r_idx;
  logic [7:0] r_sr, r_cap;
  logic r_aborted;
  logic w_shift_end;
  assign w_shift_end = (r_idx == 3'd7) || (r_cnt == LAST - 1'b1);
  assign in_ready  = r_state == FETCH;
  assign sc_en     = r_state == SHIFT;
  assign sc_in     = sc_en & r_sr[0];
  assign out_valid = r_state == EMIT;
  assign out_data  = out_valid ? r_cap : 8'h00;
  assign busy      = r_state != IDLE;
  assign done      = r_state == FIN;
  assign aborted   = r_aborted;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_sr      <= '0;
      r_cap     <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= 1'b0;
      if (abort && r_state != IDLE) begin
        r_state   <= IDLE;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          IDLE: if (start) begin
            r_cnt   <= '0;
            r_cap   <= '0;
            r_state <= FETCH;
          end
          FETCH: if (in_valid) begin
            r_sr    <= in_data;
            r_idx   <= '0;
            r_state <= SHIFT;
          end
          SHIFT: begin
            // sc_out is the chain tail before this edge's shift
            r_cap[r_idx] <= sc_out;
            r_sr  <= r_sr >> 1;
            r_idx <= r_idx + 3'd1;
            r_cnt <= r_cnt + 1'b1;
            if (w_shift_end) r_state <= EMIT;
          end
          EMIT: if (out_ready) begin
            if (r_cnt == LAST) r_state <= FIN;
            else begin
              r_cap   <= '0;
              r_state <= FETCH;
            end
          end
          FIN: r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_scan_cfg_loader.sv
// tb_scan_cfg_loader: three chain lengths driven against a behavioural scan-chain model.
module tb_scan_cfg_loader;
  localparam int LEN [3] = '{16, 12, 1};
  logic clk = 1'b0;
  logic rst;
  logic start [3], abort [3], in_valid [3], out_ready [3];
  logic [7:0] in_data [3], out_data [3];
  logic in_ready [3], out_valid [3], sc_en [3], sc_in [3], busy [3], done [3], aborted [3];
  logic [15:0] chain [3], ld_val [3];
  logic ld [3], clr [3];
  int en_cnt [3], done_cnt [3], ab_cnt [3];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  scan_cfg_loader #(.CHAIN_LEN(LEN[0])) u0 (.clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
    .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]), .out_valid(out_valid[0]),
    .out_data(out_data[0]), .out_ready(out_ready[0]), .sc_en(sc_en[0]), .sc_in(sc_in[0]),
    .sc_out(chain[0][0]), .busy(busy[0]), .done(done[0]), .aborted(aborted[0]));
  scan_cfg_loader #(.CHAIN_LEN(LEN[1])) u1 (.clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
    .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]), .out_valid(out_valid[1]),
    .out_data(out_data[1]), .out_ready(out_ready[1]), .sc_en(sc_en[1]), .sc_in(sc_in[1]),
    .sc_out(chain[1][0]), .busy(busy[1]), .done(done[1]), .aborted(aborted[1]));
  scan_cfg_loader #(.CHAIN_LEN(LEN[2])) u2 (.clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]),
    .in_valid(in_valid[2]), .in_data(in_data[2]), .in_ready(in_ready[2]), .out_valid(out_valid[2]),
    .out_data(out_data[2]), .out_ready(out_ready[2]), .sc_en(sc_en[2]), .sc_in(sc_in[2]),
    .sc_out(chain[2][0]), .busy(busy[2]), .done(done[2]), .aborted(aborted[2]));

  function automatic logic [15:0] shr(input logic [15:0] v, input int n, input logic b);
    logic [15:0] t;
    t = v >> 1;
    t[n-1] = b;
    return t;
  endfunction

  // grid model: bit 0 is the tail, sc_in enters at bit LEN-1
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ld[k]) chain[k] <= ld_val[k];
      else if (sc_en[k]) chain[k] <= shr(chain[k], LEN[k], sc_in[k]);
      if (clr[k]) begin
        en_cnt[k] <= 0;
        done_cnt[k] <= 0;
        ab_cnt[k] <= 0;
      end else begin
        en_cnt[k] <= en_cnt[k] + int'(sc_en[k]);
        done_cnt[k] <= done_cnt[k] + int'(done[k]);
        ab_cnt[k] <= ab_cnt[k] + int'(aborted[k]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_quiet(input int k, input string tag);
    chk({tag, "_sc_en"}, 32'(sc_en[k]), 0);
    chk({tag, "_sc_in"}, 32'(sc_in[k]), 0);
    chk({tag, "_in_ready"}, 32'(in_ready[k]), 0);
    chk({tag, "_out_valid"}, 32'(out_valid[k]), 0);
    chk({tag, "_out_data"}, 32'(out_data[k]), 0);
    chk({tag, "_busy"}, 32'(busy[k]), 0);
    chk({tag, "_done"}, 32'(done[k]), 0);
    chk({tag, "_aborted"}, 32'(aborted[k]), 0);
  endtask

  task automatic clear_counts(input int k);
    clr[k] = 1'b1;
    @(negedge clk);
    clr[k] = 1'b0;
  endtask

  task automatic run_load(input int k, input logic [7:0] b0, input logic [7:0] b1,
                          input int in_st, input int out_st);
    logic [7:0] bs [2];
    logic [15:0] pre;
    int nb, n, w;
    logic [31:0] exp_b;
    bs[0] = b0;
    bs[1] = b1;
    nb = (LEN[k] + 7) / 8;
    clear_counts(k);
    pre = chain[k];
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    for (int j = 0; j < nb; j++) begin
      repeat (in_st) begin
        chk("fetch_ready", 32'(in_ready[k]), 1);
        chk("fetch_stall_sc_en", 32'(sc_en[k]), 0);
        @(negedge clk);
      end
      in_valid[k] = 1'b1;
      in_data[k] = bs[j];
      @(negedge clk);
      in_valid[k] = 1'b0;
      in_data[k] = 8'($urandom);
      w = 0;
      while (!out_valid[k] && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("emit_reached", 32'(out_valid[k]), 1);
      n = (LEN[k] - 8 * j < 8) ? LEN[k] - 8 * j : 8;
      exp_b = (32'(pre) >> (8 * j)) & ((32'd1 << n) - 1);
      chk("out_data", 32'(out_data[k]), exp_b);
      repeat (out_st) begin
        @(negedge clk);
        chk("emit_stall_data", 32'(out_data[k]), exp_b);
        chk("emit_stall_sc_en", 32'(sc_en[k]), 0);
        chk("emit_stall_valid", 32'(out_valid[k]), 1);
      end
      out_ready[k] = 1'b1;
      @(negedge clk);
      out_ready[k] = 1'b0;
    end
    chk("done_pulse", 32'(done[k]), 1);
    @(negedge clk);
    chk("done_low", 32'(done[k]), 0);
    chk("idle_busy", 32'(busy[k]), 0);
    chk("chain_final", 32'(chain[k]), 32'({b1, b0}) & ((32'd1 << LEN[k]) - 1));
    chk("shift_cycles", 32'(en_cnt[k]), 32'(LEN[k]));
    chk("done_count", 32'(done_cnt[k]), 1);
    chk("abort_count", 32'(ab_cnt[k]), 0);
  endtask

  initial begin
    logic [15:0] ref_chain;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start[k] = 0; abort[k] = 0; in_valid[k] = 0; out_ready[k] = 0; in_data[k] = 0;
      ld[k] = 1'b1; clr[k] = 1'b1;
    end
    ld_val[0] = 16'hBEEF;
    ld_val[1] = 16'($urandom) & 16'h0FFF;
    ld_val[2] = 16'($urandom) & 16'h0001;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk_quiet(k, "in_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin ld[k] = 1'b0; clr[k] = 1'b0; end
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk_quiet(k, "after_reset");

    run_load(0, 8'h34, 8'h12, 0, 0);
    chk("beef_chain", 32'(chain[0]), 32'h1234);
    run_load(1, 8'hFF, 8'hFF, 0, 0);
    chk("len12_chain", 32'(chain[1]), 32'h0FFF);
    run_load(2, 8'h01, 8'h00, 0, 0);

    run_load(0, 8'hA5, 8'h3C, 0, 0);
    ref_chain = chain[0];
    run_load(0, 8'hA5, 8'h3C, 5, 7);
    chk("stall_vs_nostall", 32'(chain[0]), 32'(ref_chain));

    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("idle_abort_pulse", 32'(aborted[0]), 0);
    chk("idle_abort_busy", 32'(busy[0]), 0);
    clear_counts(0);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    in_valid[0] = 1'b1;
    in_data[0] = 8'h5A;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("abort_pulse", 32'(aborted[0]), 1);
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_sc_en", 32'(sc_en[0]), 0);
    chk("abort_in_ready", 32'(in_ready[0]), 0);
    chk("abort_out_valid", 32'(out_valid[0]), 0);
    repeat (3) @(negedge clk);
    chk_quiet(0, "post_abort");
    chk("abort_count", 32'(ab_cnt[0]), 1);
    chk("abort_no_done", 32'(done_cnt[0]), 0);
    chk("abort_shifts", 32'(en_cnt[0]), 3);
    run_load(0, 8'($urandom), 8'($urandom), 1, 1);

    clear_counts(1);
    start[1] = 1'b1;
    @(negedge clk);
    repeat (3) begin
      chk("held_start_fetch", 32'(in_ready[1]), 1);
      chk("held_start_sc_en", 32'(sc_en[1]), 0);
      @(negedge clk);
    end
    in_valid[1] = 1'b1;
    in_data[1] = 8'hC3;
    @(negedge clk);
    in_valid[1] = 1'b0;
    chk("held_start_shift", 32'(sc_en[1]), 1);
    @(negedge clk);
    rst = 1'b1;
    start[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_quiet(1, "mid_shift_rst");
    @(negedge clk);
    chk_quiet(1, "post_rst");
    chk("rst_no_abort", 32'(ab_cnt[1]), 0);
    chk("rst_no_done", 32'(done_cnt[1]), 0);

    for (int i = 0; i < 6; i++)
      for (int k = 0; k < 3; k++)
        run_load(k, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/scan_cfg_loader.md
SCAN_CFG_LOADER -- requirements
Module: scan_cfg_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 512: scan-chain length in bits, legal range 1..65535.
REQ-002 SHALL have parameter CNT_W, default 16: width of the bit counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1: request a full-chain load; sampled in IDLE only.
REQ-006 SHALL have port abort, input, 1: synchronous cancel of a load in progress.
REQ-007 SHALL have ports in_valid (input, 1), in_data (input, 8) and in_ready (output, 1): configuration byte stream, shifted LSB first.
REQ-008 SHALL have ports out_valid (output, 1), out_data (output, 8) and out_ready (input, 1): readback byte stream of the displaced chain contents, LSB first.
REQ-009 SHALL have port sc_en, output, 1: drives the grid scan enable.
REQ-010 SHALL have port sc_in, output, 1: drives the grid scan-chain input.
REQ-011 SHALL have port sc_out, input, 1: receives the grid scan-chain output.
REQ-012 SHALL have ports busy (output, 1), done (output, 1) and aborted (output, 1): status; done and aborted are one-cycle pulses.

Function
REQ-013 SHALL implement states IDLE, FETCH, SHIFT, EMIT and FIN.
REQ-014 In IDLE, start=1 SHALL clear the bit counter and capture register and move to FETCH; start in any other state SHALL be ignored.
REQ-015 In FETCH, in_ready SHALL be 1; an in_valid&in_ready cycle SHALL latch in_data into the shift register, clear the bit index and move to SHIFT.
REQ-016 in_ready SHALL be 0 in all states other than FETCH.
REQ-017 In SHIFT, sc_en SHALL be 1 and sc_in SHALL equal shift-register bit 0 every cycle, shifting one chain bit per cycle.
REQ-018 In each SHIFT cycle, sc_out SHALL be sampled before the edge and stored into capture bit [bit index], i.e. the pre-shift tail bit.
REQ-019 SHIFT SHALL leave for EMIT when 8 bits have shifted or the bit counter reaches CHAIN_LEN, whichever comes first.
REQ-020 sc_en SHALL be 0 in all states other than SHIFT, so the chain never shifts while waiting on either handshake.
REQ-021 In EMIT, out_valid SHALL be 1 and out_data SHALL hold the capture byte, stable until out_ready=1.
REQ-022 On out_valid&out_ready, the block SHALL go to FIN if the bit counter equals CHAIN_LEN, otherwise it SHALL clear the capture register and go to FETCH.
REQ-023 When CHAIN_LEN mod 8 = k≠0, the final input byte SHALL contribute only bits [k-1:0], and the final out_data bits [7:k] SHALL be 0.
REQ-024 FIN SHALL assert done for exactly one cycle and then return to IDLE.
REQ-025 busy SHALL be 1 in FETCH, SHIFT, EMIT and FIN, and 0 in IDLE.
REQ-026 The bit counter SHALL be CNT_W bits wide, never exceed CHAIN_LEN, and never wrap.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE on the next edge and pulse aborted for one cycle.
REQ-028 After an abort, sc_en, in_ready and out_valid SHALL be 0 from that next cycle onward, with no done pulse and no pending byte emitted.
REQ-029 abort in IDLE SHALL have no effect; abort has priority over start and over any handshake in the same cycle.
REQ-030 Total sc_en-high cycles per completed load SHALL equal exactly CHAIN_LEN.

Reset
REQ-031 rst=1 SHALL take precedence over abort and all other inputs.
REQ-032 rst=1 SHALL force IDLE and clear the counter, bit index, shift register and capture register.
REQ-033 During and after reset, sc_en, sc_in, in_ready, out_valid, out_data, busy, done and aborted SHALL all be 0 until the next start.
REQ-034 Reset asserted mid-load SHALL behave as an abort, except that no aborted pulse is produced.

Verification
REQ-035 CHAIN_LEN=16, chain model preloaded 0xBEEF, inputs 0x34 then 0x12, out_ready=1: out_data SHALL be 0xEF then 0xBE, the chain SHALL then hold 0x1234, done SHALL pulse once, and sc_en SHALL be high for 16 cycles.
REQ-036 CHAIN_LEN=12, inputs 0xFF then 0xFF: the chain SHALL hold 0xFFF, the second out_data SHALL have bits [7:4]=0, and there SHALL be 12 shift cycles.
REQ-037 in_valid withheld for 5 cycles and out_ready low for 7 cycles: sc_en SHALL be 0 throughout both stalls, out_data SHALL stay stable, and the final chain contents SHALL be unchanged versus the no-stall run.
REQ-038 abort on shift cycle 3 of the first byte: aborted SHALL pulse once, IDLE SHALL be reached next cycle, done SHALL never assert, and a following start SHALL complete a normal load.
REQ-039 start held high during a load, then rst pulsed mid-SHIFT: the held start SHALL be ignored while busy, and all outputs SHALL be 0 the cycle after rst.
REQ-040 CHAIN_LEN=1, input 0x01: exactly one shift cycle SHALL occur, one out byte 0x00 or 0x01 SHALL equal the prior chain bit, and then done SHALL pulse.
